dmem_mmio_responder: RTL
========================

// Module: dmem_mmio_responder
// PURPOSE
// - Responder end of the core's data-memory port: services the core's addr/memWdata/memWMask/memRstrb requests and returns memRdata.
// - Consists of a byte-maskable data RAM and a small MMIO window.
// - The MMIO window holds a console TX FIFO with a valid/ready drain port, a 64-bit cycle counter, and a sticky halt flag.
// - Sits beside the single-cycle core on one clock. The core cannot stall, so every access completes in its issue cycle.
// PARAMETERS
// - RAM_WORDS   1024  RAM depth in 32-bit words (power of 2).
// - FIFO_DEPTH  8     TX FIFO depth in bytes (power of 2, >=2).
// - INIT_FILE   ""    $readmemh image for RAM. Empty string = no init.
// PORTS
// - clk       in   1   clock, all state on posedge.
// - reset     in   1   synchronous, active-high.
// - addr      in   32  byte address from core.
// - memWdata  in   32  store data, already lane-aligned by core.
// - memWMask  in   4   byte write enables. 0 = no write.
// - memRstrb  in   1   load strobe, high during load cycle.
// - memRdata  out  32  read data, combinational from addr.
// - tx_data   out  8   head byte of TX FIFO.
// - tx_valid  out  1   FIFO non-empty.
// - tx_ready  in   1   sink accepts tx_data when tx_valid & tx_ready.
// - halt      out  1   sticky, set by a store to HALT.
// BEHAVIOUR
// - Decode: addr[22]=1 selects MMIO and the RAM is untouched. addr[22]=0 selects RAM.
// - RAM index = addr[$clog2(RAM_WORDS)+1:2]. Upper bits are ignored, so addresses wrap modulo RAM size.
// - RAM write: on posedge, byte i is written when memWMask[i]. Mixed masks (e.g. 4'b0110) are legal.
// - RAM read: asynchronous, full word. The core extracts bytes/halfwords itself.
// - RAM contents are not cleared by reset.
// - MMIO word offsets (addr[4:2]); any other offset reads 0 and ignores writes:
//   - 0 CONSOLE_TX (W): store with memWMask[0] pushes memWdata[7:0]. Reads 0.
//   - 1 STATUS (R): {16'b0, count[7:0], 5'b0, overflow, full, empty}.
//   - 2 CYCLE_LO (R): cnt[31:0]. A memRstrb read latches cnt[63:32] into hi_latch at that edge.
//   - 3 CYCLE_HI (R): hi_latch. Pair reads LO then HI is atomic.
//   - 4 HALT (W): any store sets halt=1. Reads {31'b0, halt}.
// - cnt: 64-bit counter, increments every cycle, wraps 2^64-1 -> 0.
// - FIFO: pointer + count (log2 depth + 1 bits).
//   - pop = tx_valid & tx_ready; push = CONSOLE_TX store.
//   - Empty + push: byte becomes visible on tx_data with tx_valid=1 the next cycle. No fall-through same cycle.
//   - Full + push, no pop: byte dropped, overflow sticky set, count unchanged.
//   - Full + push + pop same cycle: both take effect, push accepted, count stays FIFO_DEPTH.
//   - Empty + tx_ready: no pop. tx_data is don't-care while tx_valid=0.
//   - tx_data/tx_valid hold while tx_valid & ~tx_ready.
//   - overflow and halt clear only on reset.
// - Reset (sync, active-high): count=0, pointers=0, tx_valid=0, overflow=0, halt=0, cnt=0, hi_latch=0.
//   - Reset mid-drain: FIFO contents are discarded.
//   - memRdata is still driven combinationally during reset. RAM data is retained.
// CONFIGURATION
// - DMEM_CYCLE_COUNTER_EN defined: cnt and hi_latch are implemented as above.
// - DMEM_CYCLE_COUNTER_EN undefined: no counter flops. CYCLE_LO/CYCLE_HI read 0. All other behaviour is unchanged.
// TESTING
// - Reset 2 cycles -> tx_valid=0, halt=0, STATUS=32'h0000_0001.
// - RAM: store 32'hDEADBEEF mask 4'hF at 0x40, then mask 4'h2 data 32'h0000_5500 -> read 0x40 = 32'hDEAD55EF.
//   Read 0x40+4*RAM_WORDS -> same word (wrap).
// - FIFO with tx_ready=0: push 'A'..'H' (8 bytes) -> STATUS count=8, full=1.
//   Push 'I' -> overflow=1, count stays 8.
//   Set tx_ready=1 -> sink receives 'A'..'H' on 8 consecutive cycles, then tx_valid=0.
// - Full FIFO, push 'Z' in the same cycle as a pop -> count stays 8, 'Z' is the last byte drained, overflow unchanged.
// - With DMEM_CYCLE_COUNTER_EN: read LO at cnt=32'hFFFF_FFFF with hi=0, then HI next cycle -> HI reads 0, not 1.
//   Without the macro -> both read 0.
// - Store to addr 0x0040_0010 -> halt=1 next cycle, sticky across further accesses.
//   Assert reset mid-drain -> next cycle tx_valid=0, halt=0.

Source files
------------

// File: rtl/dmem_mmio_responder.sv
// dmem_mmio_responder: data-memory responder for the single-cycle core.
// Byte-maskable word RAM plus an MMIO window at addr[22]=1 holding a console
// TX FIFO (valid/ready drain), a 64-bit cycle counter and a sticky halt flag.
// Optional feature macro: DMEM_CYCLE_COUNTER_EN (cycle counter + HI latch).
// INIT_FILE names the RAM image handed to the implementation flow; this RTL
// leaves RAM contents unloaded and unreset.
module dmem_mmio_responder #(
    parameter int    RAM_WORDS  = 1024,
    parameter int    FIFO_DEPTH = 8,
    parameter string INIT_FILE  = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] memWdata,
    input  logic [3:0]  memWMask,
    input  logic        memRstrb,
    output logic [31:0] memRdata,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        halt
);
    localparam int AW = $clog2(RAM_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);

    // ---------------- decode ----------------
    logic          is_mmio;
    logic [2:0]    mmio_off;
    logic [AW-1:0] ram_idx;
    logic          unused_bits;

    assign is_mmio  = addr[22];
    assign mmio_off = addr[4:2];
    assign ram_idx  = addr[AW+1:2];
    // Upper address bits are don't-care (RAM wraps), the strobe only matters
    // for the counter latch.
    assign unused_bits = ^{addr, memRstrb};

    // ---------------- RAM ----------------
    logic [31:0] ram_q [RAM_WORDS];

    // Byte-lane writes; contents survive reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (!is_mmio && memWMask[i])
                ram_q[ram_idx][8*i +: 8] <= memWdata[8*i +: 8];
        end
    end

    // ---------------- TX FIFO ----------------
    logic [7:0]  fifo_q [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr;
    logic [PW:0]   count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          halt_q, halt_d;
    logic          full, empty, push_req, push_ok, pop, halt_set;

    assign full     = (count_q == (PW+1)'(FIFO_DEPTH));
    assign empty    = (count_q == '0);
    assign pop      = !empty && tx_ready;
    assign push_req = is_mmio && (mmio_off == 3'd0) && memWMask[0];
    // A pop in the same cycle frees the slot, so full+push+pop is accepted.
    assign push_ok  = push_req && (!full || pop);
    assign wr_ptr   = rd_ptr_q + count_q[PW-1:0];
    assign halt_set = is_mmio && (mmio_off == 3'd4) && (memWMask != 4'd0);

    // Next-state for FIFO bookkeeping and the sticky flags.
    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        halt_d     = halt_q || halt_set;
        if (pop)
            rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push_ok, pop})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
        if (push_req && full && !pop)
            overflow_d = 1'b1;
    end

    // Control registers; reset discards FIFO contents by zeroing pointers.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            halt_q     <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            halt_q     <= halt_d;
        end
    end

    // FIFO storage, written only on an accepted push.
    always_ff @(posedge clk) begin
        if (push_ok)
            fifo_q[wr_ptr] <= memWdata[7:0];
    end

    assign tx_data  = fifo_q[rd_ptr_q];
    assign tx_valid = !empty;
    assign halt     = halt_q;

    // ---------------- cycle counter ----------------
    logic [31:0] cyc_lo, cyc_hi;
`ifdef DMEM_CYCLE_COUNTER_EN
    logic [63:0] cnt_q;
    logic [31:0] hi_latch_q;

    // Free-running counter; a LO load snapshots HI so LO-then-HI is atomic.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q      <= '0;
            hi_latch_q <= '0;
        end else begin
            cnt_q <= cnt_q + 64'd1;
            if (is_mmio && (mmio_off == 3'd2) && memRstrb)
                hi_latch_q <= cnt_q[63:32];
        end
    end

    assign cyc_lo = cnt_q[31:0];
    assign cyc_hi = hi_latch_q;
`else
    assign cyc_lo = '0;
    assign cyc_hi = '0;
`endif

    // ---------------- read mux ----------------
    logic [31:0] mmio_rdata;

    // MMIO read decode; unmapped offsets read zero.
    always_comb begin
        mmio_rdata = '0;
        case (mmio_off)
            3'd1:    mmio_rdata = {16'h0, 8'(count_q), 5'h0, overflow_q, full, empty};
            3'd2:    mmio_rdata = cyc_lo;
            3'd3:    mmio_rdata = cyc_hi;
            3'd4:    mmio_rdata = {31'h0, halt_q};
            default: mmio_rdata = '0;
        endcase
    end

    assign memRdata = is_mmio ? mmio_rdata : ram_q[ram_idx];

endmodule
